// File: rtl/disp_step_ctrl_pkg.sv
// Shared constants for the display-input feeder: bus layout, FSM states, defaults.
package disp_step_ctrl_pkg;

    localparam int unsigned DispInBusW  = 35;
    localparam int unsigned DispHalfBit = 32;
    localparam int unsigned DispClkBit  = 33;
    localparam int unsigned DispRstBit  = 34;

    localparam int unsigned DEF_DEB_CYCLES = 1000000;
    localparam int unsigned DEF_STEP_HIGH  = 8;
    localparam int unsigned DEF_RUN_DIV    = 2500000;

    typedef logic [DispInBusW-1:0] disp_bus_t;

    localparam disp_bus_t DispRstVal = {1'b1, 34'b0};

    typedef enum logic [1:0] {
        StMan    = 2'd0,
        StStepHi = 2'd1,
        StRun    = 2'd2,
        StStop   = 2'd3
    } state_e;

endpackage

// File: rtl/disp_step_ctrl_btn_debounce.sv
// Button debouncer: 2-flop synchroniser, stability counter, rising-edge event pulse.
module btn_debounce
    import disp_step_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    localparam int unsigned CntW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [1:0]      sync_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            rise_q;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CntW'(DEB_CYCLES - 1)) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= level_d & ~level_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/disp_step_ctrl.sv
// Front-panel controller: debounced buttons, slow CPU clock (step/run), and
// packing of the observed CPU word onto the 35-bit display bus.
module disp_step_ctrl
    import disp_step_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int unsigned STEP_HIGH  = DEF_STEP_HIGH,
    parameter int unsigned RUN_DIV    = DEF_RUN_DIV
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn_step_i,
    input  logic                  btn_run_i,
    input  logic                  btn_half_i,
    input  logic                  btn_crst_i,
    input  logic [31:0]           data_i,
    output logic                  cpu_clk_o,
    output logic                  cpu_rst_o,
    output logic [DispInBusW-1:0] disp_data_o
);

    localparam int unsigned DivMax = (STEP_HIGH > RUN_DIV) ? STEP_HIGH : RUN_DIV;
    localparam int unsigned CntW   = (DivMax > 1) ? $clog2(DivMax) : 1;

    logic step_ev, run_ev, half_ev, crst_lvl;
    logic step_lvl, run_lvl, half_lvl, crst_rise;
    logic unused_ok;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
        .clk(clk), .rst(rst), .btn_i(btn_step_i), .level_o(step_lvl), .rise_o(step_ev));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
        .clk(clk), .rst(rst), .btn_i(btn_run_i), .level_o(run_lvl), .rise_o(run_ev));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_half (
        .clk(clk), .rst(rst), .btn_i(btn_half_i), .level_o(half_lvl), .rise_o(half_ev));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_crst (
        .clk(clk), .rst(rst), .btn_i(btn_crst_i), .level_o(crst_lvl), .rise_o(crst_rise));

    assign unused_ok = ^{step_lvl, run_lvl, half_lvl, crst_rise};

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            clk_q, clk_d;
    logic            cpu_rst_q;
    logic            half_q, half_d;
    disp_bus_t       disp_q, disp_d;
    logic            div_wrap;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clk_d    = clk_q;
        div_wrap = (cnt_q == CntW'(RUN_DIV - 1));
        case (state_q)
            StMan: begin
                clk_d = 1'b0;
                cnt_d = '0;
                if (run_ev) begin
                    state_d = StRun;
                end else if (step_ev) begin
                    state_d = StStepHi;
                    clk_d   = 1'b1;
                end
            end
            StStepHi: begin
                if (cnt_q == CntW'(STEP_HIGH - 1)) begin
                    cnt_d   = '0;
                    clk_d   = 1'b0;
                    state_d = StMan;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StRun: begin
                if (div_wrap) begin
                    cnt_d = '0;
                    clk_d = ~clk_q;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
                if (run_ev) state_d = StStop;
            end
            StStop: begin
                // A high phase in progress is allowed to finish its full width.
                if (!clk_q) begin
                    cnt_d   = '0;
                    state_d = StMan;
                end else if (div_wrap) begin
                    cnt_d   = '0;
                    clk_d   = 1'b0;
                    state_d = StMan;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StMan;
        endcase
    end

    always_comb begin
        half_d              = half_q ^ half_ev;
        disp_d              = disp_q;
        disp_d[DispRstBit]  = cpu_rst_q;
        disp_d[DispClkBit]  = clk_q;
        disp_d[DispHalfBit] = half_q;
        // disp_q's clock bit is last cycle's cpu_clk, so this is the falling edge.
        if (disp_q[DispClkBit] && !clk_q) disp_d[31:0] = data_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StMan;
            cnt_q     <= '0;
            clk_q     <= 1'b0;
            cpu_rst_q <= 1'b1;
            half_q    <= 1'b0;
            disp_q    <= DispRstVal;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clk_q     <= clk_d;
            cpu_rst_q <= crst_lvl;
            half_q    <= half_d;
            disp_q    <= disp_d;
        end
    end

    assign cpu_clk_o   = clk_q;
    assign cpu_rst_o   = cpu_rst_q;
    assign disp_data_o = disp_q;

endmodule

// File: tb/tb_disp_step_ctrl.sv
// Scoreboard bench for disp_step_ctrl: stimulus predicts cpu_clk pulses and
// latched data; a negedge monitor pops and compares as pulses complete.
module tb_disp_step_ctrl;

    localparam int unsigned DEB   = 4;
    localparam int unsigned STEPH = 8;
    localparam int unsigned RDIV  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  btn = '0;  // [0] step, [1] run, [2] half, [3] crst
    logic [31:0] data_i = '0;
    logic        cpu_clk_o, cpu_rst_o;
    logic [34:0] disp_data_o;

    disp_step_ctrl #(.DEB_CYCLES(DEB), .STEP_HIGH(STEPH), .RUN_DIV(RDIV)) dut (
        .clk(clk), .rst(rst),
        .btn_step_i(btn[0]), .btn_run_i(btn[1]), .btn_half_i(btn[2]), .btn_crst_i(btn[3]),
        .data_i(data_i), .cpu_clk_o(cpu_clk_o), .cpu_rst_o(cpu_rst_o), .disp_data_o(disp_data_o));

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int unsigned width; logic [31:0] data; } exp_t;
    exp_t exp_q[$];

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned pulses = 0;
    logic [31:0] last_data = '0;
    logic        half_m = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor
    logic        prev_clk = 1'b0, prev_rst = 1'b1, in_pulse = 1'b0, chk_data = 1'b0;
    int unsigned rise_cyc = 0;
    exp_t        cur;
    always @(negedge clk) begin
        if (rst) begin
            in_pulse = 1'b0;
            chk_data = 1'b0;
        end else begin
            chk("disp_clk_copy", disp_data_o[33], prev_clk);
            chk("disp_rst_copy", disp_data_o[34], prev_rst);
            if (chk_data) begin
                chk_data = 1'b0;
                chk("latched_data", disp_data_o[31:0], cur.data);
            end
            if (cpu_clk_o && !prev_clk) begin
                in_pulse = 1'b1;
                rise_cyc = cyc;
            end
            if (!cpu_clk_o && prev_clk && in_pulse) begin
                in_pulse = 1'b0;
                pulses++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", 64'(cyc - rise_cyc), 64'd0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("pulse_width", 64'(cyc - rise_cyc), 64'(cur.width));
                    chk_data = 1'b1;
                end
            end
        end
        prev_clk = cpu_clk_o;
        prev_rst = cpu_rst_o;
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // p = index of the first clock edge that samples the raw press
    task automatic press(input logic [3:0] m, input int unsigned hold, output int unsigned p);
        @(negedge clk);
        btn = btn | m;
        p   = cyc + 1;
        tick(hold);
        btn = btn & ~m;
    endtask

    task automatic do_step(input logic [31:0] d);
        int unsigned lat;
        lat    = 0;
        data_i = d;
        exp_q.push_back('{width: STEPH, data: d});
        last_data = d;
        @(negedge clk);
        btn[0] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 6) btn[0] = 1'b0;
            if (cpu_clk_o) begin
                lat = k;
                break;
            end
        end
        btn[0] = 1'b0;
        chk("step_latency", 64'(lat), 64'(2 + DEB + 1));
        tick(12);
        data_i = $urandom;
        tick(5);
        chk("data_hold_low", disp_data_o[31:0], last_data);
    endtask

    // Run then stop; the stop press is sampled gap edges after the run press.
    task automatic do_run(input logic [3:0] m, input int unsigned gap, input logic [31:0] d);
        int unsigned p, q, n;
        data_i = d;
        n = (gap - 3) / 6 + 1;  // rises at p+9+6k that happen no later than the stop at q+6
        for (int unsigned i = 0; i < n; i++) exp_q.push_back('{width: RDIV, data: d});
        last_data = d;
        press(m, 6, p);
        tick(gap - 7);
        press(4'b0010, 6, q);
        chk("stop_gap", 64'(q - p), 64'(gap));
        tick(30);
        chk("run_expect_drained", 64'(exp_q.size()), 64'd0);
        chk("run_stopped_low", cpu_clk_o, 1'b0);
    endtask

    task automatic do_half();
        int unsigned p;
        press(4'b0100, 6, p);
        tick(6);
        half_m = ~half_m;
        chk("half_sel", disp_data_o[32], half_m);
    endtask

    initial begin
        int unsigned p, snap, off, found;
        logic [31:0] d;

        // reset values while rst is held, then release mid-cycle
        @(posedge clk);
        #2;
        chk("rst_cpu_clk", cpu_clk_o, 1'b0);
        chk("rst_cpu_rst", cpu_rst_o, 1'b1);
        chk("rst_disp", disp_data_o, 35'h4_0000_0000);
        rst = 1'b0;
        found = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (!disp_data_o[34]) begin
                found = k;
                break;
            end
        end
        chk("rst_bit34_clears", 64'(found != 0), 64'd1);

        // glitches shorter than DEB produce nothing
        for (int i = 0; i < 3; i++) begin
            snap = pulses;
            press(4'(1 << i), $urandom_range(1, DEB - 1), p);
            tick(15);
            chk("glitch_no_pulse", 64'(pulses), 64'(snap));
            chk("glitch_half", disp_data_o[32], half_m);
            chk("glitch_clk_low", cpu_clk_o, 1'b0);
        end

        for (int i = 0; i < 3; i++) do_step($urandom);
        do_step(32'h1234_ABCD);

        do_half();
        do_half();
        do_half();

        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            do_run(4'b0010, (i == 0) ? 15 : $urandom_range(14, 40), d);
            tick(5);
            chk("run_last_data", disp_data_o[31:0], last_data);
        end

        // run event during a manual step is dropped
        for (int i = 0; i < 2; i++) begin
            snap = pulses;
            d = $urandom;
            data_i = d;
            exp_q.push_back('{width: STEPH, data: d});
            last_data = d;
            off = $urandom_range(1, 6);
            @(negedge clk);
            btn[0] = 1'b1;
            tick(off);
            btn[1] = 1'b1;
            tick(6 - off);
            btn[0] = 1'b0;
            tick(off);
            btn[1] = 1'b0;
            tick(30);
            chk("collide_one_pulse", 64'(pulses - snap), 64'd1);
            chk("collide_drained", 64'(exp_q.size()), 64'd0);
        end

        // simultaneous run+step: run wins, no 8-wide step pulse
        do_run(4'b0011, $urandom_range(14, 30), $urandom);

        // cpu reset held while stepping
        @(negedge clk);
        btn[3] = 1'b1;
        tick(12);
        chk("crst_on", cpu_rst_o, 1'b1);
        chk("crst_disp34", disp_data_o[34], 1'b1);
        do_step($urandom);
        btn[3] = 1'b0;
        tick(12);
        chk("crst_off", cpu_rst_o, 1'b0);

        // asynchronous reset in the middle of a run high phase
        data_i = $urandom;
        press(4'b0010, 6, p);
        tick(5);
        chk("midrun_high", cpu_clk_o, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrun_rst_clk", cpu_clk_o, 1'b0);
        chk("midrun_rst_cpu_rst", cpu_rst_o, 1'b1);
        chk("midrun_rst_disp", disp_data_o, 35'h4_0000_0000);
        half_m = 1'b0;
        last_data = '0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        snap = pulses;
        tick(20);
        chk("post_rst_idle", cpu_clk_o, 1'b0);
        chk("post_rst_no_pulse", 64'(pulses), 64'(snap));
        chk("final_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

endmodule
